// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host: FSM states, frame lengths and
// the microsecond-to-cycle conversion used to size the timers.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_INHIBIT,
    ST_TX_REQ,
    ST_TX_BITS,
    ST_TX_ACK
  } ps2_state_e;

  // RX: start, 8 data, parity, stop. TX: 8 data, parity, stop, then one ACK clock.
  localparam int unsigned RX_FRAME_BITS = 11;
  localparam int unsigned TX_FRAME_BITS = 10;

  function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned us);
    longint unsigned prod;
    prod = clk_hz * us;
    return 32'((prod + 64'd999_999) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_host_if.sv
// Client-side bus of the PS/2 host: command TX handshake, RX FIFO read
// port and the one-cycle status pulses.
interface ps2_host_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] rx_count;
  logic          tx_ack;
  logic          err_parity;
  logic          err_timeout;
  logic          err_overflow;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_count,
    input  tx_ack, err_parity, err_timeout, err_overflow
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_count,
    output tx_ack, err_parity, err_timeout, err_overflow
  );
endinterface

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push and
// a pop in the same cycle are both honoured, even when full.
module ps2_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         drop_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  // When full, a concurrent pop frees the slot the write lands in.
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/ps2_host.sv
// Bidirectional PS/2 host: line synchroniser/filter, frame FSM for device
// reception and host commands, and an RX FIFO toward the client.
module ps2_host
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        ps2clk_i,
  input  logic        ps2data_i,
  output logic        ps2clk_oe,
  output logic        ps2data_oe,
  ps2_host_if.slave   bus
);
  localparam int unsigned INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC  = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned TMR_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned FW      = $clog2(FILTER_LEN + 1);

  // Index 0 = clock line, 1 = data line.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          fe, din;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      clk_prev_q <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q    <= {ps2data_i, ps2clk_i};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fe  = clk_prev_q & ~filt_q[0];
  assign din = filt_q[1];

  ps2_state_e state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          push_q, push_d, tx_ack_q, tx_ack_d;
  logic          err_par_q, err_par_d, err_to_q, err_to_d, err_ovf_q, ovf;
  logic          in_frame;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      timer_q   <= '0;
      rx_byte_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      push_q    <= 1'b0;
      tx_ack_q  <= 1'b0;
      err_par_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      timer_q   <= timer_d;
      rx_byte_q <= rx_byte_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      push_q    <= push_d;
      tx_ack_q  <= tx_ack_d;
      err_par_q <= err_par_d;
      err_to_q  <= err_to_d;
      err_ovf_q <= ovf;
    end
  end

  assign in_frame = (state_q == ST_RX) || (state_q == ST_TX_BITS) || (state_q == ST_TX_ACK);

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    timer_d   = timer_q;
    rx_byte_d = rx_byte_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    push_d    = 1'b0;
    tx_ack_d  = 1'b0;
    err_par_d = 1'b0;
    err_to_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        timer_d   = '0;
        bitcnt_d  = '0;
        if (fe && !din) begin
          state_d = ST_RX;
        end else if (bus.tx_valid) begin
          shreg_d  = {1'b1, ~^bus.tx_data, bus.tx_data};
          clk_oe_d = 1'b1;
          state_d  = ST_TX_INHIBIT;
        end
      end
      ST_RX: if (fe) begin
        // Bits enter at the top; after 9 shifts [8:1] = data, [9] = parity.
        shreg_d  = {din, shreg_q[9:1]};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == 4'(RX_FRAME_BITS - 2)) begin
          rx_byte_d = shreg_q[8:1];
          if ((^shreg_q[9:1]) && din) push_d = 1'b1;
          else                        err_par_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_TX_INHIBIT: begin
        if (timer_q == TW'(INH_CYC - 1)) begin
          timer_d   = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_TX_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_TX_REQ: begin
        bitcnt_d = '0;
        timer_d  = '0;
        state_d  = ST_TX_BITS;
      end
      ST_TX_BITS: if (fe) begin
        data_oe_d = ~shreg_q[0];
        shreg_d   = {1'b1, shreg_q[9:1]};
        bitcnt_d  = bitcnt_q + 1'b1;
        if (bitcnt_q == 4'(TX_FRAME_BITS - 1)) state_d = ST_TX_ACK;
      end
      ST_TX_ACK: if (fe) begin
        if (!din) tx_ack_d = 1'b1;
        else      err_to_d = 1'b1;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Inter-edge watchdog shared by every state that waits on device clocks.
    if (in_frame) begin
      if (fe) begin
        timer_d = '0;
      end else if (timer_q == TW'(TO_CYC - 1)) begin
        err_to_d  = 1'b1;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_q),
    .data_i  (rx_byte_q),
    .pop_i   (bus.rx_ready),
    .data_o  (bus.rx_data),
    .valid_o (bus.rx_valid),
    .count_o (bus.rx_count),
    .drop_o  (ovf)
  );

  assign ps2clk_oe        = clk_oe_q;
  assign ps2data_oe       = data_oe_q;
  assign bus.tx_ready     = (state_q == ST_IDLE);
  assign bus.tx_ack       = tx_ack_q;
  assign bus.err_parity   = err_par_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.err_overflow = err_ovf_q;

endmodule

// File: tb/tb_ps2_host.sv
// Bench for ps2_host: behavioural PS/2 device on the pads, scoreboard queues
// of expected RX bytes, status pulses and host commands.
module tb_ps2_host;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned H       = 20;
  localparam int unsigned INH_EXP = 2500;
  localparam int unsigned TO_EXP  = 50_000;
  localparam int EV_PAR = 1, EV_TMO = 2, EV_OVF = 3, EV_ACK = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2clk_oe, ps2data_oe, ps2clk_pad, ps2data_pad;

  assign ps2clk_pad  = dev_clk  & ~ps2clk_oe;
  assign ps2data_pad = dev_data & ~ps2data_oe;

  ps2_host_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_host #(
    .CLK_HZ     (25_000_000),
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (8),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .ps2clk_i   (ps2clk_pad),
    .ps2data_i  (ps2data_pad),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int occ = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int         exp_evt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0);
  endfunction

  // Reference: a frame is accepted when stop=1 and data+parity has an odd
  // number of ones; while the reader is held off, a full FIFO drops it.
  task automatic rx_model(input logic [7:0] b, input logic par, input logic stop, input bit held);
    if (!stop || (($countones(b) + int'(par)) % 2 == 0)) exp_evt.push_back(EV_PAR);
    else if (held && occ == DEPTH) exp_evt.push_back(EV_OVF);
    else begin
      exp_rx.push_back(b);
      if (held) occ++;
    end
  endtask

  task automatic dev_send(input logic [7:0] b, input logic par, input logic stop,
                          input int unsigned nbits);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      dev_data = fr[i];
      cyc(H / 2);
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      cyc(H / 2);
    end
    dev_data = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic par, input logic stop, input bit held);
    rx_model(b, par, stop, held);
    dev_send(b, par, stop, 11);
    cyc(30);
  endtask

  // Device side of a host command: times the inhibit, clocks the frame,
  // compares it with the queued command and answers with (or without) ACK.
  task automatic dev_recv(input bit ack);
    int unsigned n;
    logic [9:0] got;
    logic [9:0] want;
    logic [7:0] b;
    n = 0;
    while (!ps2clk_oe && n < 100) begin cyc(1); n++; end
    check("inhibit_start", {31'd0, ps2clk_oe}, 32'd1);
    n = 0;
    while (ps2clk_oe && n < 5000) begin cyc(1); n++; end
    check("inhibit_cycles", n, INH_EXP);
    check("start_bit_oe", {31'd0, ps2data_oe}, 32'd1);
    cyc(H);
    for (int unsigned i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      cyc(H / 2);
      got[i] = ps2data_pad;
      cyc(H / 2);
    end
    if (exp_tx.size() == 0) begin
      total++; bad++;
      $display("FAIL tx_frame: got 0x%0h, no command queued", got);
    end else begin
      b = exp_tx.pop_front();
      want = {1'b1, good_par(b), b};
      check("tx_frame", {22'd0, got}, {22'd0, want});
    end
    if (ack) dev_data = 1'b0;
    cyc(H / 2);
    dev_clk = 1'b0;
    cyc(H);
    dev_clk = 1'b1;
    cyc(H / 2);
    dev_data = 1'b1;
    cyc(H);
  endtask

  task automatic host_tx(input logic [7:0] b, input bit ack);
    exp_tx.push_back(b);
    exp_evt.push_back(ack ? EV_ACK : EV_TMO);
    check("tx_ready_idle", {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    dev_recv(ack);
  endtask

  task automatic ev_seen(input int code, input string nm);
    int e;
    if (exp_evt.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: pulse seen, none expected", nm);
    end else begin
      e = exp_evt.pop_front();
      check(nm, code, e);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_rx.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_data: got 0x%0h, no byte expected", bus.rx_data);
        end else begin
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_rx.pop_front()});
        end
      end
      if (bus.err_parity)   ev_seen(EV_PAR, "err_parity");
      if (bus.err_timeout)  ev_seen(EV_TMO, "err_timeout");
      if (bus.err_overflow) ev_seen(EV_OVF, "err_overflow");
      if (bus.tx_ack)       ev_seen(EV_ACK, "tx_ack");
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic par, stop;
    int unsigned kind, n, el;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    cyc(3);
    check("rst_clk_oe",   {31'd0, ps2clk_oe}, 32'd0);
    check("rst_data_oe",  {31'd0, ps2data_oe}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_count", {29'd0, bus.rx_count}, 32'd0);
    check("rst_rx_data",  {24'd0, bus.rx_data}, 32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_pulses",   {28'd0, bus.tx_ack, bus.err_parity, bus.err_timeout, bus.err_overflow}, 32'd0);
    rstn = 1'b1;
    cyc(20);

    // Single good byte, held in the FIFO, then read.
    send_rx(8'h1C, good_par(8'h1C), 1'b1, 1'b0);
    check("rx1_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("rx1_head",  {24'd0, bus.rx_data}, 32'h1C);
    check("rx1_count", {29'd0, bus.rx_count}, 32'd1);
    bus.rx_ready = 1'b1;
    cyc(5);
    check("rx1_drained", {29'd0, bus.rx_count}, 32'd0);

    // Wrong parity: dropped.
    bus.rx_ready = 1'b0;
    send_rx(8'h1C, ~good_par(8'h1C), 1'b1, 1'b0);
    check("par_count", {29'd0, bus.rx_count}, 32'd0);

    // Overflow: five bytes into a four-entry FIFO with the reader stalled.
    occ = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_rx(b, good_par(b), 1'b1, 1'b1);
    end
    check("ovf_count", {29'd0, bus.rx_count}, 32'd4);
    bus.rx_ready = 1'b1;
    cyc(20);
    check("ovf_drained", {29'd0, bus.rx_count}, 32'd0);

    // Random frames with occasional parity/stop faults.
    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      par  = good_par(b) ^ (kind == 0);
      stop = (kind != 1);
      send_rx(b, par, stop, 1'b0);
    end

    // Host commands: mouse enable, a random byte, and one left unacknowledged.
    host_tx(8'hF4, 1'b1);
    host_tx(8'($urandom), 1'b1);
    host_tx(8'($urandom), 1'b0);

    // Device clock stalls after four bits.
    exp_evt.push_back(EV_TMO);
    dev_send(8'hA5, 1'b0, 1'b1, 4);
    n = 0;
    while (!bus.err_timeout && n < 60_000) begin cyc(1); n++; end
    el = n + (3 * H / 2);
    check("timeout_window", {31'd0, (el >= TO_EXP && el <= TO_EXP + 20)}, 32'd1);
    cyc(2);
    check("timeout_idle", {31'd0, bus.tx_ready}, 32'd1);
    send_rx(8'h3B, good_par(8'h3B), 1'b1, 1'b0);

    // Reset while a command is being clocked out, with a byte waiting.
    bus.rx_ready = 1'b0;
    dev_send(8'h5A, good_par(8'h5A), 1'b1, 11);
    cyc(30);
    check("pre_rst_count", {29'd0, bus.rx_count}, 32'd1);
    bus.tx_data  = 8'hED;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    n = 0;
    while (!ps2clk_oe && n < 100) begin cyc(1); n++; end
    while (ps2clk_oe && n < 5000) begin cyc(1); n++; end
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; cyc(H); dev_clk = 1'b1; cyc(H);
    end
    check("mid_tx_data_oe", {31'd0, ps2data_oe}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_tx_clk_oe",  {31'd0, ps2clk_oe}, 32'd0);
    check("rst_tx_data_oe", {31'd0, ps2data_oe}, 32'd0);
    check("rst_tx_ready",   {31'd0, bus.tx_ready}, 32'd1);
    check("rst_tx_count",   {29'd0, bus.rx_count}, 32'd0);
    check("rst_tx_valid",   {31'd0, bus.rx_valid}, 32'd0);
    cyc(3);
    rstn = 1'b1;
    bus.rx_ready = 1'b1;
    cyc(20);

    check("rx_queue_empty",  exp_rx.size(), 32'd0);
    check("evt_queue_empty", exp_evt.size(), 32'd0);
    check("tx_queue_empty",  exp_tx.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host.md
# ps2_host

Parametrised bidirectional PS/2 host controller that replaces the per-core receivers (keyboard-only, mouse-only) with a single block. It filters and synchronises the PS/2 lines, receives device frames into a configurable FIFO, and transmits host commands (e.g. mouse 0xF4 enable, keyboard LED 0xED). Separate input and open-drain-enable pins are used, so the top level never needs INOUT pads. It sits between the pad ring and the display/decoder logic on the pixel clock.

## Interface

Parameters:
- CLK_HZ, 25_000_000: clk_i frequency, used to derive the µs timers.
- FIFO_DEPTH, 8: RX FIFO entries; must be a power of two, ≥2.
- FILTER_LEN, 8: cycles a synchronised line must be stable before its filtered value changes.
- INHIBIT_US, 100: time the host holds clock low before a TX request.
- TIMEOUT_US, 2000: maximum gap between device clock falling edges inside a frame.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- ps2clk_i  in  1  raw PS/2 clock pad input.
- ps2data_i  in  1  raw PS/2 data pad input.
- ps2clk_oe  out  1  1 = drive clock pad low, 0 = release.
- ps2data_oe  out  1  1 = drive data pad low, 0 = release.
- tx_data  in  8  command byte.
- tx_valid  in  1  command request.
- tx_ready  out  1  host is idle and can accept a command.
- rx_data  out  8  FIFO head byte.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop the FIFO head.
- rx_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- tx_ack  out  1  1-cycle pulse: the device acknowledged a command.
- err_parity  out  1  1-cycle pulse: RX parity or stop-bit error; the byte is dropped.
- err_timeout  out  1  1-cycle pulse: a frame was aborted by the timeout, or a TX frame got no ACK.
- err_overflow  out  1  1-cycle pulse: an RX byte was dropped because the FIFO was full.

## Operation

- Inputs pass through a 2-FF synchroniser, then a FILTER_LEN stable-counter filter. A falling edge (fe) is a 1→0 transition of the filtered clock, held for 1 cycle.
- The FSM has these states: IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK.
- **IDLE**
  - fe with filtered data = 0 → RX, bit count 0.
  - tx_valid & tx_ready → latch tx_data, compute odd parity → TX_INHIBIT.
  - RX start wins if both occur in the same cycle; tx_valid stays pending.
- **RX**
  - Sample data on each fe, LSB first: 8 data bits, then parity, then stop.
  - On the stop bit: odd parity OK and stop = 1 → push the byte; otherwise err_parity.
  - Return to IDLE.
- **TX_INHIBIT**: ps2clk_oe = 1 for INHIBIT_US, then → TX_REQ.
- **TX_REQ**: ps2data_oe = 1 (start bit), release the clock, → TX_BITS.
- **TX_BITS**
  - On each fe, drive the next bit (ps2data_oe = ~bit): 8 data bits, parity, then stop (released).
  - After the 10th fe → TX_ACK.
- **TX_ACK**: on the next fe, data = 0 → tx_ack pulse; data = 1 → err_timeout. Either way → IDLE.
- **Timeout**: in RX/TX_BITS/TX_ACK, a counter is cleared on each fe. Reaching TIMEOUT_US → err_timeout, both OE lines released, → IDLE.
- **FIFO**
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (count unchanged).
  - A push into a full FIFO with no pop → byte dropped, err_overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- tx_ready = (state == IDLE).

## Timing

- Reset values:
  - ps2clk_oe = ps2data_oe = 0.
  - rx_valid = 0, rx_count = 0, rx_data = 0.
  - All error pulses and tx_ack = 0.
  - tx_ready = 1 (IDLE).
  - Filters preset to 1 (idle-high lines).
- Pad-to-fe latency: 2 (sync) + FILTER_LEN + 1 cycles.
- The stop-bit fe in cycle N produces a push in N+1 and rx_valid = 1 in N+2.
  - rx_data is registered and first-word-fall-through: valid while rx_valid.
  - Pop on rx_valid & rx_ready; the next head is visible in the following cycle.
- Timer counts are CLK_HZ/1_000_000 × US, computed at elaboration and rounded up.
- Reset asserted mid-frame: the FSM goes to IDLE immediately, OE lines are released asynchronously, and the FIFO is emptied.
- The ps2clk_oe rising edge to ps2data_oe assertion in TX_REQ is exactly 1 cycle after the inhibit timer expires.

## Structure

- Package ps2_pkg holds:
  - the FSM state encoding;
  - the frame bit-count constants (RX 11, TX 10 + ACK);
  - a function converting µs to cycles.
- Sub-module ps2_fifo: synchronous FWFT FIFO parametrised by WIDTH and DEPTH, with count output and same-cycle push/pop.
- The filter and the FSM stay in ps2_host.

## Test plan

- **RX byte**: device model sends 0x1C with correct parity → rx_valid, rx_data = 0x1C, rx_count = 1; no error pulses.
- **RX parity error**: 0x1C sent with even parity → err_parity pulse, rx_count stays 0.
- **TX command**: tx_data = 0xF4 with model ACK →
  - ps2clk_oe high for 2500 cycles at 25 MHz;
  - then start bit, LSB-first bits 0,0,1,0,1,1,1,1, parity 0, stop;
  - tx_ack pulse; model receives 0xF4.
- **Overflow**: with FIFO_DEPTH = 4, send 5 bytes with rx_ready = 0 → rx_count = 4, one err_overflow; bytes 1-4 read back in order.
- **Timeout**: stop the device clock after 4 bits → err_timeout after 50_000 cycles, FSM in IDLE, next full frame received correctly.
- **Reset mid-TX**: assert rstn_i during TX_BITS → both OE lines 0 and tx_ready = 1 immediately; FIFO empty.
